mem_bus_arbiter: RTL
====================

Name: mem_bus_arbiter

Overview:
- Shares one SRAM-like memory bus between the instruction-fetch port (read-only) and the data port (load/store requests from the MEM stage, with byte strobes).
- Runs exactly one bus transaction at a time. The granted request is registered, driven on the bus, and its read data is returned with a one-cycle done pulse.
- Generates the pipeline stall request.
- Data has priority over fetch, with a starvation limit. A flush input discards an in-flight fetch without breaking the bus protocol.

Parameters:
- ADDR_W, 32, address width of all ports.
- DATA_W, 32, data width; strobe width is DATA_W/8.
- STARVE_LIMIT, 4, number of consecutive data grants while a fetch waits, after which the fetch is granted next (range 1..15).

Ports:
- clk  in  1  clock; all state on rising edge.
- resetn  in  1  asynchronous, active-low reset.
- inst_req  in  1  fetch request; held high until inst_done.
- inst_addr  in  ADDR_W  fetch address, word aligned.
- inst_rdata  out  DATA_W  fetched word; valid while inst_done=1.
- inst_done  out  1  one-cycle completion pulse.
- data_req  in  1  load/store request; held high until data_done.
- data_wr  in  1  1 = store, 0 = load.
- data_size  in  2  0 = byte, 1 = half, 2 = word.
- data_addr  in  ADDR_W  access address; already aligned by the MEM stage.
- data_wstrb  in  DATA_W/8  store byte select.
- data_wdata  in  DATA_W  store data, already byte-replicated.
- data_rdata  out  DATA_W  raw load word; valid while data_done=1.
- data_done  out  1  one-cycle completion pulse.
- flush  in  1  exception/eret flush; kills the fetch.
- stall_req  out  1  combinational pipeline stall.
- bus_req  out  1  SRAM-like request.
- bus_wr  out  1  SRAM-like write.
- bus_size  out  2  SRAM-like size.
- bus_addr  out  ADDR_W  SRAM-like address.
- bus_wstrb  out  DATA_W/8  SRAM-like write strobe.
- bus_wdata  out  DATA_W  SRAM-like write data.
- bus_addr_ok  in  1  address accepted.
- bus_data_ok  in  1  data returned or write done.
- bus_rdata  in  DATA_W  SRAM-like read data.

Behaviour:

Reset:
- resetn=0 forces IDLE immediately, regardless of any transaction in progress.
- All registered outputs reset to 0, the starvation counter to 0, and the discard flag to 0.
- No partial completion is reported after reset.

State machine (states IDLE, ADDR, DATA, RESP):
- IDLE: if data_req and not (inst_req and starve_cnt==STARVE_LIMIT), grant data. Else if inst_req and not flush, grant fetch. Else stay in IDLE.
- On grant: latch owner, wr, size, addr, wstrb and wdata into registers; go to ADDR.
  - Fetch grant latches wr=0, size=2, wstrb=0.
- ADDR: bus_req=1 with the latched fields. On bus_addr_ok, go to DATA. Registers are stable until then.
- DATA: bus_req=0. On bus_data_ok, capture bus_rdata into the owner's rdata register and go to RESP.
- RESP: the owner's done=1 for exactly one cycle, unless the discard flag is set; then go to IDLE unconditionally.
- A new grant is never made in RESP. The requester deasserts or updates its req at the RESP clock edge.

Latency:
- Minimum is 3 cycles from req sampled in IDLE to the done cycle: IDLE→ADDR with addr_ok=1, ADDR→DATA with data_ok=1, DATA→RESP.
- With zero bus wait, back-to-back accesses from one port are 4 cycles apart.

Starvation counter:
- Increments on each data grant while inst_req=1; saturates at STARVE_LIMIT.
- Clears on any fetch grant, and whenever inst_req=0 in IDLE.

Flush:
- In IDLE, a flush blocks a fetch grant that cycle.
- While the owner is the fetch (ADDR, DATA or RESP), flush sets the discard flag. The bus transaction still completes normally: bus_req is not dropped before addr_ok, and data_ok is still awaited.
- In RESP with discard set, inst_done is 0 and inst_rdata is not updated. Discard clears on entry to IDLE.
- Flush has no effect on a data-owned transaction.

stall_req:
- stall_req = (inst_req & ~inst_done) | (data_req & ~data_done).

Simultaneous events and boundaries:
- addr_ok and data_ok in the same cycle while in ADDR: take only ADDR→DATA. data_ok is expected no earlier than the cycle after addr_ok; a same-cycle data_ok is protocol misuse.
- data_ok in ADDR: ignored.
- flush in the same cycle as data_ok: discard still applies.

Widths:
- Addresses and data pass through unmodified.
- bus_wstrb is 0 for all reads.

Test Plan:
1. Single load: data_req=1, wr=0, addr=0x1000_0004, bus addr_ok=1 immediately, data_ok next cycle with rdata=0xDEADBEEF → bus_req high exactly 1 cycle with addr 0x1000_0004; data_done pulses 3 cycles after req; data_rdata=0xDEADBEEF; stall_req=1 until the done cycle, then 0.
2. Store byte: data_wr=1, size=0, addr=0x20, wstrb=4'b0100, wdata=0x5A5A5A5A, addr_ok delayed 3 cycles → bus_req held 4 cycles with stable fields; data_done pulses once; data_rdata is don't-care.
3. Contention: inst_req and data_req both high in IDLE → data granted first, fetch second; inst_done follows data_done by at least 4 cycles.
4. Starvation: data_req held high for back-to-back loads while inst_req=1, STARVE_LIMIT=4 → after 4 data grants the 5th grant is the fetch; counter then clears.
5. Flush: fetch granted, flush pulsed in DATA; data_ok returns 0x1234_5678 → transaction completes, inst_done stays 0, inst_rdata unchanged, FSM back in IDLE 1 cycle after RESP.
6. Reset mid-op: resetn=0 while in DATA → immediately IDLE, bus_req=0, no done pulse; after release, a new load completes normally.

Source files
------------

// File: rtl/mem_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mem_bus_arbiter
// Description : Shares one SRAM-like bus between the instruction-fetch port
//               and the data port; one transaction at a time, data priority
//               with a fetch starvation limit, and flush-safe fetch discard.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_bus_arbiter #(
    parameter int ADDR_W       = 32,
    parameter int DATA_W       = 32,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                clk,
    input  logic                resetn,
    // instruction fetch port
    input  logic                inst_req,
    input  logic [ADDR_W-1:0]   inst_addr,
    output logic [DATA_W-1:0]   inst_rdata,
    output logic                inst_done,
    // data port
    input  logic                data_req,
    input  logic                data_wr,
    input  logic [1:0]          data_size,
    input  logic [ADDR_W-1:0]   data_addr,
    input  logic [DATA_W/8-1:0] data_wstrb,
    input  logic [DATA_W-1:0]   data_wdata,
    output logic [DATA_W-1:0]   data_rdata,
    output logic                data_done,
    // pipeline control
    input  logic                flush,
    output logic                stall_req,
    // SRAM-like bus
    output logic                bus_req,
    output logic                bus_wr,
    output logic [1:0]          bus_size,
    output logic [ADDR_W-1:0]   bus_addr,
    output logic [DATA_W/8-1:0] bus_wstrb,
    output logic [DATA_W-1:0]   bus_wdata,
    input  logic                bus_addr_ok,
    input  logic                bus_data_ok,
    input  logic [DATA_W-1:0]   bus_rdata
);

    localparam int         STRB_W         = DATA_W / 8;
    localparam logic [3:0] c_STARVE_LIMIT = 4'(STARVE_LIMIT);
    localparam logic [1:0] c_SIZE_WORD    = 2'd2;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ADDR = 2'd1,
        S_DATA = 2'd2,
        S_RESP = 2'd3
    } state_t;

    state_t              r_state;
    logic                r_owner_inst;
    logic [3:0]          r_starve_cnt;
    logic                r_discard;
    logic                r_bus_req;
    logic                r_bus_wr;
    logic [1:0]          r_bus_size;
    logic [ADDR_W-1:0]   r_bus_addr;
    logic [STRB_W-1:0]   r_bus_wstrb;
    logic [DATA_W-1:0]   r_bus_wdata;
    logic [DATA_W-1:0]   r_inst_rdata;
    logic [DATA_W-1:0]   r_data_rdata;
    logic                r_inst_done;
    logic                r_data_done;

    logic                w_fetch_starved;
    logic                w_grant_data;
    logic                w_grant_inst;
    logic                w_kill_fetch;
    logic                w_fetch_discarded;

    // A waiting fetch that has seen STARVE_LIMIT data grants takes the next slot.
    assign w_fetch_starved   = inst_req && (r_starve_cnt == c_STARVE_LIMIT);
    assign w_grant_data      = data_req && !w_fetch_starved;
    assign w_grant_inst      = !w_grant_data && inst_req && !flush;
    assign w_kill_fetch      = r_owner_inst && flush;
    assign w_fetch_discarded = r_discard || flush;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state      <= S_IDLE;
            r_owner_inst <= 1'b0;
            r_starve_cnt <= 4'd0;
            r_discard    <= 1'b0;
            r_bus_req    <= 1'b0;
            r_bus_wr     <= 1'b0;
            r_bus_size   <= 2'd0;
            r_bus_addr   <= '0;
            r_bus_wstrb  <= '0;
            r_bus_wdata  <= '0;
            r_inst_rdata <= '0;
            r_data_rdata <= '0;
            r_inst_done  <= 1'b0;
            r_data_done  <= 1'b0;
        end else begin
            r_inst_done <= 1'b0;
            r_data_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (!inst_req) begin
                        r_starve_cnt <= 4'd0;
                    end
                    if (w_grant_data) begin
                        r_owner_inst <= 1'b0;
                        r_bus_req    <= 1'b1;
                        r_bus_wr     <= data_wr;
                        r_bus_size   <= data_size;
                        r_bus_addr   <= data_addr;
                        r_bus_wstrb  <= data_wr ? data_wstrb : '0;
                        r_bus_wdata  <= data_wdata;
                        if (inst_req && (r_starve_cnt != c_STARVE_LIMIT)) begin
                            r_starve_cnt <= r_starve_cnt + 4'd1;
                        end
                        r_state      <= S_ADDR;
                    end else if (w_grant_inst) begin
                        r_owner_inst <= 1'b1;
                        r_bus_req    <= 1'b1;
                        r_bus_wr     <= 1'b0;
                        r_bus_size   <= c_SIZE_WORD;
                        r_bus_addr   <= inst_addr;
                        r_bus_wstrb  <= '0;
                        r_bus_wdata  <= '0;
                        r_starve_cnt <= 4'd0;
                        r_state      <= S_ADDR;
                    end
                end
                S_ADDR: begin
                    if (w_kill_fetch) begin
                        r_discard <= 1'b1;
                    end
                    // A data_ok arriving while still in ADDR is not a completion.
                    if (bus_addr_ok) begin
                        r_bus_req <= 1'b0;
                        r_state   <= S_DATA;
                    end
                end
                S_DATA: begin
                    if (w_kill_fetch) begin
                        r_discard <= 1'b1;
                    end
                    if (bus_data_ok) begin
                        if (r_owner_inst) begin
                            if (!w_fetch_discarded) begin
                                r_inst_rdata <= bus_rdata;
                                r_inst_done  <= 1'b1;
                            end
                        end else begin
                            r_data_rdata <= bus_rdata;
                            r_data_done  <= 1'b1;
                        end
                        r_state <= S_RESP;
                    end
                end
                S_RESP: begin
                    r_discard <= 1'b0;
                    r_state   <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign inst_rdata = r_inst_rdata;
    assign inst_done  = r_inst_done;
    assign data_rdata = r_data_rdata;
    assign data_done  = r_data_done;
    assign bus_req    = r_bus_req;
    assign bus_wr     = r_bus_wr;
    assign bus_size   = r_bus_size;
    assign bus_addr   = r_bus_addr;
    assign bus_wstrb  = r_bus_wstrb;
    assign bus_wdata  = r_bus_wdata;

    assign stall_req  = (inst_req && !r_inst_done) || (data_req && !r_data_done);

endmodule
`default_nettype wire
